// File: rtl/gauss_row_feeder_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_row_feeder_pkg
//  Brief    : Shared defaults, processor op codes and feeder FSM encoding.
//  Revision : 1.0
// ============================================================================
package gauss_row_feeder_pkg;

    localparam int GF_BIT_DEF      = 4;
    localparam int OP_CODE_LEN_DEF = 4;

    localparam logic [OP_CODE_LEN_DEF-1:0] OP_GAUSS    = 4'd1;
    localparam logic [OP_CODE_LEN_DEF-1:0] OP_KEY      = 4'd3;
    localparam logic [OP_CODE_LEN_DEF-1:0] OP_EVAL     = 4'd4;
    localparam logic [OP_CODE_LEN_DEF-1:0] OP_SWAP     = 4'd5;
    localparam logic [OP_CODE_LEN_DEF-1:0] OP_MUL_RAND = 4'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } feeder_state_t;

endpackage : gauss_row_feeder_pkg
`default_nettype wire

// File: rtl/gauss_row_feeder_lane_skew_delay.sv
`default_nettype none
// ============================================================================
//  Module   : lane_skew_delay
//  Brief    : DEPTH-stage free-running shift register; DEPTH=0 is a plain wire.
//  Revision : 1.0
// ============================================================================
module lane_skew_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = clk ^ rst;
            assign dout     = din;
        end else begin : g_shift
            logic [WIDTH-1:0] shreg_q [DEPTH];
            logic [WIDTH-1:0] shreg_d [DEPTH];

            always_comb begin
                shreg_d[0] = din;
                for (int i = 1; i < DEPTH; i++) begin
                    shreg_d[i] = shreg_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    shreg_q <= '{default: '0};
                end else begin
                    shreg_q <= shreg_d;
                end
            end

            assign dout = shreg_q[DEPTH-1];
        end
    endgenerate

endmodule : lane_skew_delay
`default_nettype wire

// File: rtl/gauss_row_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : gauss_row_feeder
//  Brief    : Accepts one matrix row per handshake and skews it into N_COL
//             tagged column lanes feeding the GF systolic array.
//  Revision : 1.0
// ============================================================================
module gauss_row_feeder
    import gauss_row_feeder_pkg::*;
#(
    parameter int GF_BIT      = GF_BIT_DEF,
    parameter int N_COL       = 8,
    parameter int OP_CODE_LEN = OP_CODE_LEN_DEF,
    parameter int ROW_W       = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cmd_start,
    input  logic [ROW_W-1:0]            cmd_rows,
    input  logic [OP_CODE_LEN-1:0]      cmd_op,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [N_COL*GF_BIT-1:0]     s_row,
    output logic [N_COL*GF_BIT-1:0]     lane_data,
    output logic [N_COL-1:0]            lane_valid,
    output logic [N_COL-1:0]            lane_start,
    output logic [N_COL-1:0]            lane_finish,
    output logic [N_COL*OP_CODE_LEN-1:0] lane_op,
    output logic                        busy,
    output logic                        done,
    output logic                        bubble_err
);

    localparam int DCW = $clog2(N_COL + 1);
    localparam int EW  = GF_BIT + 3 + OP_CODE_LEN;

    feeder_state_t            state_q,      state_d;
    logic [ROW_W-1:0]         rows_q,       rows_d;
    logic [ROW_W-1:0]         rows_left_q,  rows_left_d;
    logic [OP_CODE_LEN-1:0]   op_q,         op_d;
    logic [DCW-1:0]           drain_cnt_q,  drain_cnt_d;
    logic                     bubble_err_q, bubble_err_d;
    logic [N_COL*GF_BIT-1:0]  s0_data_q,    s0_data_d;
    logic                     s0_valid_q,   s0_valid_d;
    logic                     s0_start_q,   s0_start_d;
    logic                     s0_finish_q,  s0_finish_d;
    logic [OP_CODE_LEN-1:0]   s0_op_q,      s0_op_d;
    logic                     w_accept;

    always_comb begin
        state_d      = state_q;
        rows_d       = rows_q;
        rows_left_d  = rows_left_q;
        op_d         = op_q;
        drain_cnt_d  = drain_cnt_q;
        bubble_err_d = bubble_err_q;
        // Stage 0 defaults to a bubble; only an accepted row overrides it.
        s0_data_d    = '0;
        s0_valid_d   = 1'b0;
        s0_start_d   = 1'b0;
        s0_finish_d  = 1'b0;
        s0_op_d      = '0;
        s_ready      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        w_accept     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    rows_d       = cmd_rows;
                    rows_left_d  = cmd_rows;
                    op_d         = cmd_op;
                    bubble_err_d = 1'b0;
                    if (cmd_rows == '0) begin
                        // Nothing to flush: one DRAIN cycle, then done.
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DCW'(1);
                    end else begin
                        state_d = ST_FEED;
                    end
                end
            end
            ST_FEED: begin
                busy     = 1'b1;
                s_ready  = (rows_left_q != '0);
                w_accept = s_valid && (rows_left_q != '0);
                if (w_accept) begin
                    s0_data_d   = s_row;
                    s0_valid_d  = 1'b1;
                    s0_start_d  = (rows_left_q == rows_q);
                    s0_finish_d = (rows_left_q == ROW_W'(1));
                    s0_op_d     = op_q;
                    rows_left_d = rows_left_q - ROW_W'(1);
                    if (rows_left_q == ROW_W'(1)) begin
                        state_d     = ST_DRAIN;
                        drain_cnt_d = DCW'(N_COL);
                    end
                end else begin
                    bubble_err_d = 1'b1;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (drain_cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    drain_cnt_d = drain_cnt_q - DCW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            rows_q       <= '0;
            rows_left_q  <= '0;
            op_q         <= '0;
            drain_cnt_q  <= '0;
            bubble_err_q <= 1'b0;
            s0_data_q    <= '0;
            s0_valid_q   <= 1'b0;
            s0_start_q   <= 1'b0;
            s0_finish_q  <= 1'b0;
            s0_op_q      <= '0;
        end else begin
            state_q      <= state_d;
            rows_q       <= rows_d;
            rows_left_q  <= rows_left_d;
            op_q         <= op_d;
            drain_cnt_q  <= drain_cnt_d;
            bubble_err_q <= bubble_err_d;
            s0_data_q    <= s0_data_d;
            s0_valid_q   <= s0_valid_d;
            s0_start_q   <= s0_start_d;
            s0_finish_q  <= s0_finish_d;
            s0_op_q      <= s0_op_d;
        end
    end

    assign bubble_err = bubble_err_q;

    generate
        for (genvar j = 0; j < N_COL; j++) begin : g_lane
            logic [EW-1:0] w_in;
            logic [EW-1:0] w_out;

            assign w_in = {s0_data_q[j*GF_BIT +: GF_BIT], s0_valid_q,
                           s0_start_q, s0_finish_q, s0_op_q};

            lane_skew_delay #(
                .WIDTH (EW),
                .DEPTH (j)
            ) u_skew (
                .clk  (clk),
                .rst  (rst),
                .din  (w_in),
                .dout (w_out)
            );

            assign lane_data[j*GF_BIT +: GF_BIT]           = w_out[EW-1 -: GF_BIT];
            assign lane_valid[j]                           = w_out[OP_CODE_LEN+2];
            assign lane_start[j]                           = w_out[OP_CODE_LEN+1];
            assign lane_finish[j]                          = w_out[OP_CODE_LEN];
            assign lane_op[j*OP_CODE_LEN +: OP_CODE_LEN]   = w_out[OP_CODE_LEN-1:0];
        end
    endgenerate

endmodule : gauss_row_feeder
`default_nettype wire

// File: tb/tb_gauss_row_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gauss_row_feeder
//  Brief    : Directed scoreboard bench for gauss_row_feeder (N_COL=4, GF(16)).
//  Revision : 1.0
// ============================================================================
module tb_gauss_row_feeder;

    localparam int GF  = 4;
    localparam int NC  = 4;
    localparam int OPL = 4;
    localparam int RW  = 8;
    localparam int W   = NC * GF;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_start;
    logic [RW-1:0]    cmd_rows;
    logic [OPL-1:0]   cmd_op;
    logic             s_valid;
    logic             s_ready;
    logic [W-1:0]     s_row;
    logic [W-1:0]     lane_data;
    logic [NC-1:0]    lane_valid;
    logic [NC-1:0]    lane_start;
    logic [NC-1:0]    lane_finish;
    logic [NC*OPL-1:0] lane_op;
    logic             busy;
    logic             done;
    logic             bubble_err;

    gauss_row_feeder #(
        .GF_BIT      (GF),
        .N_COL       (NC),
        .OP_CODE_LEN (OPL),
        .ROW_W       (RW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_start   (cmd_start),
        .cmd_rows    (cmd_rows),
        .cmd_op      (cmd_op),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_row       (s_row),
        .lane_data   (lane_data),
        .lane_valid  (lane_valid),
        .lane_start  (lane_start),
        .lane_finish (lane_finish),
        .lane_op     (lane_op),
        .busy        (busy),
        .done        (done),
        .bubble_err  (bubble_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int             cyc;
        logic [GF-1:0]  data;
        logic           st;
        logic           fin;
        logic [OPL-1:0] op;
    } exp_t;

    exp_t       lq [NC][$];
    int         done_q [$];
    int         checks   = 0;
    int         failures = 0;
    logic [W-1:0] rowbuf [4];

    // Monitor: pops expected lane elements / done pulses when the DUT shows them.
    always @(negedge clk) begin
        logic [GF-1:0]  d;
        logic [OPL-1:0] o;
        exp_t           e;
        int             dc;
        for (int j = 0; j < NC; j++) begin
            d = lane_data[j*GF +: GF];
            o = lane_op[j*OPL +: OPL];
            checks++;
            if (lane_valid[j]) begin
                if (lq[j].size() == 0) begin
                    failures++;
                    $display("FAIL lane%0d_unexpected: got valid data=%h at cyc %0d, required no element", j, d, cyc);
                end else begin
                    e = lq[j].pop_front();
                    if (e.cyc != cyc || e.data != d || e.st != lane_start[j] ||
                        e.fin != lane_finish[j] || e.op != o) begin
                        failures++;
                        $display("FAIL lane%0d_elem: got cyc=%0d data=%h st=%b fin=%b op=%h, required cyc=%0d data=%h st=%b fin=%b op=%h",
                                 j, cyc, d, lane_start[j], lane_finish[j], o, e.cyc, e.data, e.st, e.fin, e.op);
                    end
                end
            end else begin
                if (d != '0 || lane_start[j] || lane_finish[j] || o != '0) begin
                    failures++;
                    $display("FAIL lane%0d_bubble: got data=%h st=%b fin=%b op=%h at cyc %0d, required all zero",
                             j, d, lane_start[j], lane_finish[j], o, cyc);
                end else if (lq[j].size() > 0 && lq[j][0].cyc <= cyc) begin
                    failures++;
                    e = lq[j].pop_front();
                    $display("FAIL lane%0d_missing: got no valid at cyc %0d, required data=%h at cyc %0d",
                             j, cyc, e.data, e.cyc);
                end
            end
        end
        if (done) begin
            checks++;
            if (done_q.size() == 0) begin
                failures++;
                $display("FAIL done_unexpected: got done at cyc %0d, required none", cyc);
            end else begin
                dc = done_q.pop_front();
                if (dc != cyc) begin
                    failures++;
                    $display("FAIL done_cycle: got cyc %0d, required cyc %0d", cyc, dc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues cmd_start with a dummy row present to show nothing is accepted in IDLE.
    task automatic start_pass(input logic [RW-1:0] rows, input logic [OPL-1:0] op);
        cmd_start = 1'b1;
        cmd_rows  = rows;
        cmd_op    = op;
        s_valid   = 1'b1;
        s_row     = 16'hDEAD;
        chk("idle_s_ready", 32'(s_ready), 32'd0);
        if (rows == '0) done_q.push_back(cyc + 2);
        tick();
        cmd_start = 1'b0;
        s_valid   = 1'b0;
    endtask

    task automatic send_rows(input int n, input logic [OPL-1:0] op,
                             input int bubble_before, input int restart_at);
        exp_t e;
        int   k;
        for (int i = 0; i < n; i++) begin
            if (i == bubble_before) begin
                s_valid = 1'b0;
                tick();
            end
            s_valid = 1'b1;
            s_row   = rowbuf[i];
            if (i == restart_at) begin
                cmd_start = 1'b1;
                cmd_rows  = 8'd7;
            end
            k = 0;
            while (!s_ready && k < 20) begin
                tick();
                k++;
            end
            if (!s_ready) begin
                checks++;
                failures++;
                $display("FAIL s_ready_timeout: got s_ready=0 for row %0d, required 1", i);
            end
            for (int j = 0; j < NC; j++) begin
                e.cyc  = cyc + 1 + j;
                e.data = rowbuf[i][j*GF +: GF];
                e.st   = (i == 0);
                e.fin  = (i == n - 1);
                e.op   = op;
                lq[j].push_back(e);
            end
            if (i == n - 1) done_q.push_back(cyc + NC + 1);
            tick();
            cmd_start = 1'b0;
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        int pend;
        k = 0;
        while ((busy || done_q.size() != 0) && k < 200) begin
            tick();
            k++;
        end
        chk({name, "_busy_end"}, 32'(busy), 32'd0);
        chk({name, "_s_ready_end"}, 32'(s_ready), 32'd0);
        pend = done_q.size();
        for (int j = 0; j < NC; j++) pend += lq[j].size();
        chk({name, "_pending"}, 32'(pend), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_start = 1'b0;
        cmd_rows  = '0;
        cmd_op    = '0;
        s_valid   = 1'b0;
        s_row     = '0;
        repeat (3) tick();
        chk("rst_lane_valid", 32'(lane_valid), 32'd0);
        chk("rst_lane_data", 32'(lane_data), 32'd0);
        chk("rst_flags", 32'({lane_start, lane_finish}), 32'd0);
        chk("rst_lane_op", 32'(lane_op), 32'd0);
        chk("rst_ctl", 32'({s_ready, busy, done, bubble_err}), 32'd0);
        rst = 1'b0;
        tick();

        // 1: three contiguous rows, op GAUSS
        rowbuf[0] = 16'h4321; rowbuf[1] = 16'h8765; rowbuf[2] = 16'hCBA9;
        start_pass(8'd3, 4'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send_rows(3, 4'd1, -1, -1);
        wait_idle("t1");
        chk("t1_bubble_err", 32'(bubble_err), 32'd0);

        // 2: single row -> start and finish together
        rowbuf[0] = 16'h0F1E;
        start_pass(8'd1, 4'd3);
        send_rows(1, 4'd3, -1, -1);
        wait_idle("t2");

        // 3: one-cycle gap before row 2
        rowbuf[0] = 16'h3A5C; rowbuf[1] = 16'h96E1; rowbuf[2] = 16'h7D24;
        start_pass(8'd3, 4'd4);
        send_rows(3, 4'd4, 2, -1);
        wait_idle("t3");
        chk("t3_bubble_err", 32'(bubble_err), 32'd1);
        repeat (3) tick();
        chk("t3_bubble_sticky", 32'(bubble_err), 32'd1);

        // 4: cmd_start during FEED is ignored
        rowbuf[0] = 16'h1234; rowbuf[1] = 16'h5678; rowbuf[2] = 16'h9ABC;
        start_pass(8'd3, 4'd5);
        chk("t4_bubble_clr", 32'(bubble_err), 32'd0);
        send_rows(3, 4'd5, -1, 1);
        wait_idle("t4");
        chk("t4_bubble_err", 32'(bubble_err), 32'd0);

        // 5: reset in DRAIN, then a clean pass
        rowbuf[0] = 16'hA1B2; rowbuf[1] = 16'hC3D4; rowbuf[2] = 16'hE5F6;
        start_pass(8'd3, 4'd6);
        send_rows(3, 4'd6, -1, -1);
        tick();
        rst = 1'b1;
        tick();
        for (int j = 0; j < NC; j++) lq[j].delete();
        done_q.delete();
        chk("t5_lane_valid", 32'(lane_valid), 32'd0);
        chk("t5_lane_data", 32'(lane_data), 32'd0);
        chk("t5_flags", 32'({lane_start, lane_finish}), 32'd0);
        chk("t5_lane_op", 32'(lane_op), 32'd0);
        chk("t5_ctl", 32'({s_ready, busy, done, bubble_err}), 32'd0);
        rst = 1'b0;
        repeat (10) tick();
        rowbuf[0] = 16'h1357; rowbuf[1] = 16'h2468;
        start_pass(8'd2, 4'd6);
        send_rows(2, 4'd6, -1, -1);
        wait_idle("t5b");

        // 6: zero-row pass
        start_pass(8'd0, 4'd1);
        chk("t6_busy", 32'(busy), 32'd1);
        wait_idle("t6");
        repeat (8) tick();
        chk("t6_bubble_err", 32'(bubble_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_gauss_row_feeder
`default_nettype wire
